// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the control decoder.
// Holds the opcode encodings, the bubble word and the fetch-width constants.
// Also holds the opcode legality helper used by fetch and decode.
package riscv_pkg;

    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [6:0]  OPC_LD    = 7'b0000011;
    localparam logic [6:0]  OPC_SD    = 7'b0100011;
    localparam logic [6:0]  OPC_BEQ   = 7'b1100011;

    // addi x0,x0,0 -- the bubble placed in IF/ID on flush or halt
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // One 32-bit instruction is fetched per cycle
    localparam int FETCH_BYTES = 4;
    localparam int FETCH_SHIFT = 2;

    // True for the opcodes this core actually implements
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LD) ||
               (opc == OPC_SD)    || (opc == OPC_BEQ);
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction ROM, one 32-bit word per address.
// Latency: combinational read.
// Backpressure: none; the caller decides whether to use the word.
module instr_rom #(
    parameter int MEM_DEPTH = 256,
    parameter     INIT_FILE = "program.mem",
    // ROM contents; word i sits at bits [32*i +: 32]
    parameter logic [MEM_DEPTH*32-1:0] INIT_IMAGE = '0,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);

    assign rdata = INIT_IMAGE[addr*32 +: 32];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, ROM read and IF/ID register feeding the decoder.
// Latency: the word at PC p appears on instr_out one cycle after pc == p.
// Backpressure: stall holds PC and IF/ID; a branch redirect overrides stall; halt overrides both.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          MEM_DEPTH = 256,
    parameter              INIT_FILE = "program.mem",
    parameter logic [31:0] NOP_INSTR = INSTR_NOP,
    parameter logic [MEM_DEPTH*32-1:0] INIT_IMAGE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic [6:0]      opcode,
    output logic            instr_valid,
    output logic            illegal_op,
    output logic            halted
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] word_idx;
    logic            past_end;
    logic [PC_W-1:0] redirect_pc;
    logic [AW-1:0]   rom_addr;
    logic [31:0]     rom_rdata;

    // Word index of the next fetch; reading at or beyond MEM_DEPTH stops fetch
    assign word_idx    = pc >> FETCH_SHIFT;
    assign past_end    = (word_idx >= PC_W'(MEM_DEPTH));
    // Redirects are word aligned: the low two target bits are dropped
    assign redirect_pc = branch_target & ~PC_W'(FETCH_BYTES - 1);
    assign rom_addr    = pc[AW+FETCH_SHIFT-1:FETCH_SHIFT];

    instr_rom #(
        .MEM_DEPTH  (MEM_DEPTH),
        .INIT_FILE  (INIT_FILE),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_rom (
        .addr  (rom_addr),
        .rdata (rom_rdata)
    );

    // PC, IF/ID and halt flag; priority reset > halted > branch > stall > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            pc_out      <= '0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (halted) begin
            // Frozen until reset; redirects and stalls no longer matter
            pc          <= pc;
        end else if (branch_taken) begin
            pc          <= redirect_pc;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (stall) begin
            // Hold everything; this cycle's ROM word is dropped
            pc          <= pc;
        end else if (past_end) begin
            halted      <= 1'b1;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            instr_out   <= rom_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_W'(FETCH_BYTES);
        end
    end

    // Decoder-facing opcode and legality flag, derived straight from IF/ID
    always_comb begin
        opcode     = instr_out[6:0];
        illegal_op = instr_valid & ~is_legal_opcode(instr_out[6:0]);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven main sequence plus reset and halt corners.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Tagged instruction word so each ROM slot is distinguishable
    function automatic logic [31:0] mkw(input int idx, input logic [6:0] opc);
        logic [7:0] tag;
        tag = idx[7:0];
        return {12'hA5A, tag, 5'd0, opc};
    endfunction

    // Program A: LD, R, SD, BEQ, AUIPC (illegal), then R-type
    function automatic logic [6:0] opc_a(input int idx);
        case (idx)
            0:       return OPC_LD;
            1:       return OPC_RTYPE;
            2:       return OPC_SD;
            3:       return OPC_BEQ;
            4:       return OPC_AUIPC;
            default: return OPC_RTYPE;
        endcase
    endfunction

    function automatic logic [16*32-1:0] build_a();
        logic [16*32-1:0] img;
        img = '0;
        for (int i = 0; i < 16; i++) img[i*32 +: 32] = mkw(i, opc_a(i));
        return img;
    endfunction

    function automatic logic [4*32-1:0] build_b();
        logic [4*32-1:0] img;
        img = '0;
        for (int i = 0; i < 4; i++) img[i*32 +: 32] = mkw(i, opc_a(i));
        return img;
    endfunction

    localparam logic [16*32-1:0] IMG_A = build_a();
    localparam logic [4*32-1:0]  IMG_B = build_b();

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1, stall_a = 1'b0, br_a = 1'b0;
    logic [31:0] tgt_a = '0;
    logic [31:0] pc_out_a, instr_a;
    logic [6:0]  opc_out_a;
    logic        valid_a, ill_a, halted_a;

    logic        reset_b = 1'b1, stall_b = 1'b0, br_b = 1'b0;
    logic [31:0] tgt_b = '0;
    logic [31:0] pc_out_b, instr_b;
    logic [6:0]  opc_out_b;
    logic        valid_b, ill_b, halted_b;

    instr_fetch #(.PC_W(32), .MEM_DEPTH(16), .INIT_FILE(""), .INIT_IMAGE(IMG_A)) dut_a (
        .clk(clk), .reset(reset_a), .stall(stall_a), .branch_taken(br_a),
        .branch_target(tgt_a), .pc_out(pc_out_a), .instr_out(instr_a),
        .opcode(opc_out_a), .instr_valid(valid_a), .illegal_op(ill_a), .halted(halted_a)
    );

    instr_fetch #(.PC_W(32), .MEM_DEPTH(4), .INIT_FILE(""), .INIT_IMAGE(IMG_B)) dut_b (
        .clk(clk), .reset(reset_b), .stall(stall_b), .branch_taken(br_b),
        .branch_target(tgt_b), .pc_out(pc_out_b), .instr_out(instr_b),
        .opcode(opc_out_b), .instr_valid(valid_b), .illegal_op(ill_b), .halted(halted_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[16];

    task automatic check_a(input string tag, input logic ev, input logic cpc,
                           input logic [31:0] epc, input logic eill);
        logic [31:0] ew;
        ew = ev ? mkw(int'(epc >> 2), opc_a(int'(epc >> 2))) : INSTR_NOP;
        check({tag, ".valid"},  32'(valid_a),   32'(ev));
        if (cpc) check({tag, ".pc_out"}, pc_out_a, epc);
        check({tag, ".instr"},  instr_a,        ew);
        check({tag, ".opcode"}, 32'(opc_out_a), 32'(ew[6:0]));
        check({tag, ".illegal"}, 32'(ill_a),    32'(eill));
        check({tag, ".halted"}, 32'(halted_a),  32'(0));
    endtask

    initial begin
        //            stall br  tgt    valid chkpc pc     ill
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0E, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h12, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b0};

        // Reset held two cycles: all reset values visible
        step();
        step();
        check_a("reset", 1'b0, 1'b1, 32'h0, 1'b0);

        // Main sequence: advance, stall, branch, branch+stall, illegal opcode
        reset_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stall_a = vecs[i].stall;
            br_a    = vecs[i].br;
            tgt_a   = vecs[i].tgt;
            step();
            check_a($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_pc,
                    vecs[i].exp_pc, vecs[i].exp_ill);
        end

        // Reset during a stall with a branch pending: reset wins on that edge
        stall_a = 1'b1; br_a = 1'b1; tgt_a = 32'h20; reset_a = 1'b1;
        step();
        check_a("midreset", 1'b0, 1'b1, 32'h0, 1'b0);
        reset_a = 1'b0; stall_a = 1'b0; br_a = 1'b0;
        step();
        check_a("after_midreset", 1'b1, 1'b1, 32'h0, 1'b0);

        // Halt: depth-4 ROM runs past its end
        stall_a = 1'b1;
        step();
        check("b.reset_halted", 32'(halted_b), 32'(0));
        check("b.reset_valid",  32'(valid_b),  32'(0));
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b.seq%0d.pc", i),     pc_out_b,       32'(i * 4));
            check($sformatf("b.seq%0d.opcode", i), 32'(opc_out_b), 32'(opc_a(i)));
            check($sformatf("b.seq%0d.valid", i),  32'(valid_b),   32'(1));
        end
        step();
        check("b.halt.halted", 32'(halted_b), 32'(1));
        check("b.halt.valid",  32'(valid_b),  32'(0));
        check("b.halt.instr",  instr_b,       INSTR_NOP);
        check("b.halt.ill",    32'(ill_b),    32'(0));

        // Branch to 0 while halted is ignored
        br_b = 1'b1; tgt_b = 32'h0;
        step();
        br_b = 1'b0;
        step();
        step();
        check("b.halt_br.halted", 32'(halted_b), 32'(1));
        check("b.halt_br.valid",  32'(valid_b),  32'(0));
        check("b.halt_br.pc",     pc_out_b,      32'h0C);

        // Reset clears halt and fetch restarts at 0
        reset_b = 1'b1;
        step();
        check("b.clear.halted", 32'(halted_b), 32'(0));
        check("b.clear.pc",     pc_out_b,      32'h0);
        reset_b = 1'b0;
        step();
        check("b.restart.valid", 32'(valid_b),   32'(1));
        check("b.restart.opc",   32'(opc_out_b), 32'(OPC_LD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
